mag_frame_decimator: RTL

Parametrised multi-channel magnitude decimator for the DSBPM signal chain. It accepts a channel-serial stream of unsigned per-channel magnitudes (one frame = CHANNEL_COUNT beats) and sums each channel over a runtime-selected number of frames. It emits one channel-serial frame of sums per decimation period. It sits between the per-turn magnitude stage and the FA/SA recorders and replaces fixed-channel, fixed-rate summing with channel count, width and decimation depth set by parameters.

---
 rtl/mag_frame_decimator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mag_frame_decimator.sv
// Multi-channel magnitude decimator: sums each channel of a channel-serial
// magnitude stream over a runtime-selected number of frames and emits one
// channel-serial frame of sums per decimation period, one cycle after the
// beat that completes it.
module mag_frame_decimator #(
    parameter int CHANNEL_COUNT  = 8,
    parameter int MAG_WIDTH      = 26,
    parameter int MAX_DECIMATE   = 2000,
    parameter int DECIMATE_WIDTH = 11,
    parameter int SUM_WIDTH      = MAG_WIDTH + DECIMATE_WIDTH,
    parameter int CH_WIDTH       = $clog2(CHANNEL_COUNT)
) (
    input  logic                      i_sysClk,
    input  logic                      i_sysReset_n,
    input  logic [DECIMATE_WIDTH-1:0] i_decimateFactor,
    input  logic                      i_magValid,
    input  logic                      i_magFirst,
    input  logic [MAG_WIDTH-1:0]      i_magData,
    output logic                      o_sumValid,
    output logic                      o_sumFirst,
    output logic [CH_WIDTH-1:0]       o_sumChannel,
    output logic [SUM_WIDTH-1:0]      o_sumData,
    output logic [31:0]               o_periodCount,
    output logic                      o_seqError,
    input  logic                      i_clearError
);

    localparam logic [CH_WIDTH-1:0]       LAST_CHAN = CH_WIDTH'(CHANNEL_COUNT - 1);
    localparam logic [DECIMATE_WIDTH-1:0] MAX_DEC_W = DECIMATE_WIDTH'(MAX_DECIMATE);
    localparam logic [DECIMATE_WIDTH-1:0] ONE_DEC   = DECIMATE_WIDTH'(1);

    logic [CH_WIDTH-1:0]       r_chanIdx;
    logic [DECIMATE_WIDTH-1:0] r_frameIdx;
    logic [DECIMATE_WIDTH-1:0] r_factor;
    logic [SUM_WIDTH-1:0]      r_acc [CHANNEL_COUNT];
    logic                      r_sumValid;
    logic                      r_sumFirst;
    logic [CH_WIDTH-1:0]       r_sumChannel;
    logic [SUM_WIDTH-1:0]      r_sumData;
    logic [31:0]               r_periodCount;
    logic                      r_seqError;

    logic                      w_dropBeat;
    logic                      w_shortFrame;
    logic                      w_accept;
    logic [CH_WIDTH-1:0]       w_effChan;
    logic [DECIMATE_WIDTH-1:0] w_effFrame;
    logic [DECIMATE_WIDTH-1:0] w_clampFactor;
    logic [DECIMATE_WIDTH-1:0] w_factor;
    logic [SUM_WIDTH-1:0]      w_accPrev;
    logic [SUM_WIDTH-1:0]      w_sum;
    logic                      w_lastFrame;
    logic                      w_lastChan;

    // Classify the incoming beat, resolve the effective channel/frame slot
    // (a short frame restarts the period at channel 0) and form the new sum.
    always_comb begin
        w_dropBeat    = i_magValid && (r_chanIdx == '0) && !i_magFirst;
        w_shortFrame  = i_magValid && (r_chanIdx != '0) && i_magFirst;
        w_accept      = i_magValid && !w_dropBeat;
        w_effChan     = w_shortFrame ? '0 : r_chanIdx;
        w_effFrame    = w_shortFrame ? '0 : r_frameIdx;
        w_clampFactor = i_decimateFactor;
        if (i_decimateFactor == '0) begin
            w_clampFactor = ONE_DEC;
        end else if (i_decimateFactor > MAX_DEC_W) begin
            w_clampFactor = MAX_DEC_W;
        end
        w_factor    = ((w_effChan == '0) && (w_effFrame == '0)) ? w_clampFactor : r_factor;
        w_accPrev   = (w_effFrame == '0) ? '0 : r_acc[w_effChan];
        w_sum       = w_accPrev + SUM_WIDTH'(i_magData);
        w_lastFrame = (w_effFrame == (w_factor - ONE_DEC));
        w_lastChan  = (w_effChan == LAST_CHAN);
    end

    // Advance channel/frame position, latch the factor at period start,
    // count completed periods and register the output beat.
    always_ff @(posedge i_sysClk or negedge i_sysReset_n) begin
        if (!i_sysReset_n) begin
            r_chanIdx     <= '0;
            r_frameIdx    <= '0;
            r_factor      <= ONE_DEC;
            r_periodCount <= '0;
            r_sumValid    <= 1'b0;
            r_sumFirst    <= 1'b0;
            r_sumChannel  <= '0;
            r_sumData     <= '0;
        end else begin
            r_sumValid <= w_accept && w_lastFrame;
            if (w_accept) begin
                r_factor     <= w_factor;
                r_sumFirst   <= (w_effChan == '0);
                r_sumChannel <= w_effChan;
                r_sumData    <= w_sum;
                if (w_lastChan) begin
                    r_chanIdx <= '0;
                    if (w_lastFrame) begin
                        r_frameIdx    <= '0;
                        r_periodCount <= r_periodCount + 32'd1;
                    end else begin
                        r_frameIdx <= w_effFrame + ONE_DEC;
                    end
                end else begin
                    r_chanIdx  <= w_effChan + CH_WIDTH'(1);
                    r_frameIdx <= w_effFrame;
                end
            end
        end
    end

    // Per-channel accumulators; the first frame of a period overwrites.
    always_ff @(posedge i_sysClk or negedge i_sysReset_n) begin
        if (!i_sysReset_n) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_accept) begin
            r_acc[w_effChan] <= w_sum;
        end
    end

    // Sticky framing error; a new error outranks a simultaneous clear.
    always_ff @(posedge i_sysClk or negedge i_sysReset_n) begin
        if (!i_sysReset_n) begin
            r_seqError <= 1'b0;
        end else if (w_dropBeat || w_shortFrame) begin
            r_seqError <= 1'b1;
        end else if (i_clearError) begin
            r_seqError <= 1'b0;
        end
    end

    assign o_sumValid    = r_sumValid;
    assign o_sumFirst    = r_sumFirst;
    assign o_sumChannel  = r_sumChannel;
    assign o_sumData     = r_sumData;
    assign o_periodCount = r_periodCount;
    assign o_seqError    = r_seqError;

endmodule
